adc128_reader: RTL and testbench
================================

ADC128_READER -- requirements
Module: adc128_reader

Interface
REQ-001 Parameter: CLK_DIV, default 13, sysclk cycles per ADC_SCLK half-period; legal range 2..255; 13 gives 1.92 MHz SCLK from 50 MHz.
REQ-002 Port: sysclk  in  1  sole clock; all logic on rising edge.
REQ-003 Port: sysreset  in  1  synchronous, active-high reset.
REQ-004 Port: start  in  1  one-cycle conversion request, sampled together with channel.
REQ-005 Port: channel  in  3  ADC channel to address in this frame.
REQ-006 Port: busy  out  1  high from the cycle after start is accepted until sample_valid.
REQ-007 Port: sample  out  12  last converted value, held until next sample_valid.
REQ-008 Port: sample_channel  out  3  channel that sample belongs to.
REQ-009 Port: sample_valid  out  1  one-cycle pulse; sample/sample_channel update that cycle.
REQ-010 Port: ADC_CS_N  out  1  ADC chip select, active low.
REQ-011 Port: ADC_SCLK  out  1  serial clock, idles high.
REQ-012 Port: ADC_SADDR  out  1  serial address to ADC DIN.
REQ-013 Port: ADC_SDAT  in  1  serial data from ADC DOUT.

Function
REQ-014 States: IDLE, SETUP, SHIFT, HOLD; all outputs registered.
REQ-015 IDLE: start=1 accepted; next cycle state=SETUP, busy=1, ADC_CS_N=0, channel latched; start while busy ignored.
REQ-016 SETUP: CLK_DIV cycles, ADC_SCLK high, then SHIFT.
REQ-017 SHIFT: 16 bit periods k=0..15, each CLK_DIV cycles low then CLK_DIV cycles high; ADC_SCLK falls at start of each period.
REQ-018 ADC_SADDR updated on the sysclk edge that drives ADC_SCLK low; value = latched channel[2], [1], [0] for k=2, 3, 4, else 0.
REQ-019 ADC_SDAT captured into a 16-bit shift register, MSB first, on the sysclk edge that drives ADC_SCLK high.
REQ-020 After k=15 high phase: HOLD for CLK_DIV cycles, ADC_CS_N=1, ADC_SCLK=1, ADC_SADDR=0.
REQ-021 End of HOLD: return to IDLE; that cycle sample_valid=1, busy=0, sample=shift[11:0], sample_channel=previous-frame channel.
REQ-022 ADC converts the channel addressed in the previous frame; block keeps prev_channel register, updated to latched channel at end of each frame; first frame after reset reports channel 0.
REQ-023 Frame length start-to-sample_valid = 34*CLK_DIV + 1 cycles (443 at default).
REQ-024 start in the sample_valid cycle is accepted (back-to-back frames; CS_N high for at least CLK_DIV+1 cycles).
REQ-025 Upper four captured bits are discarded without check.

Reset
REQ-026 sysreset in any state, including mid-SHIFT: next cycle state=IDLE, ADC_CS_N=1, ADC_SCLK=1, ADC_SADDR=0, busy=0, sample_valid=0, sample=0, sample_channel=0, prev_channel=0, counters=0.
REQ-027 Frame aborted by reset produces no sample_valid.

Structure
REQ-028 Frame length (16), address bit positions (2..4) and MCU register indices DR_ADC_CTRL, SR_ADC_DATA are `defines in header.v.
REQ-029 Single module, no sub-module; one half-period counter and one 4-bit bit counter.
REQ-030 MCU access via std_reg instances in the top level; the block itself carries no MCU register logic.

Verification
REQ-031 Bench ADC model: shifts 12-bit value MSB first after four zeros on SCLK falling edges; checks CS/SCLK timing; records DIN bits 2..4 at SCLK rises.
REQ-032 Reset, start ch=5, model value 0xABC -> SADDR decodes 5; sample_valid at cycle 443; sample=0xABC, sample_channel=0.
REQ-033 Second start ch=2 in sample_valid cycle, model 0x123 -> accepted; sample=0x123, sample_channel=5; CS_N high exactly CLK_DIV+1 cycles.
REQ-034 start pulses every 50 cycles during frame -> ignored; exactly one sample_valid per accepted start.
REQ-035 sysreset at bit 7 of SHIFT -> next cycle CS_N=1, SCLK=1, busy=0; no sample_valid; next frame reports sample_channel=0.
REQ-036 CLK_DIV=2, model 0xFFF then 0x000 -> frames of 69 cycles; samples 0xFFF, 0x000; SCLK high/low each exactly 2 cycles.

Source files
------------

// File: rtl/adc128_reader_pkg.sv
// Shared types and frame constants for the ADC128S022 serial reader.
package adc128_reader_pkg;

    localparam int FRAME_BITS  = 16;
    localparam int SAMPLE_BITS = 12;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD
    } state_t;

    typedef struct packed {
        logic [2:0]             channel;
        logic [SAMPLE_BITS-1:0] data;
    } result_t;

    // DIN carries the next channel address MSB first in frame bits 2..4.
    function automatic logic addr_bit(input logic [3:0] k, input logic [2:0] ch);
        case (k)
            4'd2:    return ch[2];
            4'd3:    return ch[1];
            4'd4:    return ch[0];
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/adc128_reader.sv
// Single-frame SPI reader for an ADC128S022: addresses the next channel while
// shifting out the conversion of the channel addressed in the previous frame.
module adc128_reader
    import adc128_reader_pkg::*;
#(
    parameter int unsigned CLK_DIV = 13
) (
    input  logic        sysclk,
    input  logic        sysreset,
    input  logic        start,
    input  logic [2:0]  channel,
    output logic        busy,
    output logic [11:0] sample,
    output logic [2:0]  sample_channel,
    output logic        sample_valid,
    output logic        ADC_CS_N,
    output logic        ADC_SCLK,
    output logic        ADC_SADDR,
    input  logic        ADC_SDAT
);

    localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);
    localparam logic [3:0] BIT_LAST  = 4'(FRAME_BITS - 1);

    state_t                 state, state_d;
    logic [7:0]             hcnt, hcnt_d;
    logic [3:0]             bcnt, bcnt_d;
    logic [SAMPLE_BITS-1:0] shreg, shreg_d;
    logic [2:0]             ch_lat, ch_lat_d;
    logic [2:0]             prev_ch, prev_ch_d;
    result_t                res, res_d;
    logic                   busy_q, busy_d;
    logic                   valid_q, valid_d;
    logic                   cs_n_q, cs_n_d;
    logic                   sclk_q, sclk_d;
    logic                   saddr_q, saddr_d;
    logic                   half_done;

    always_comb begin
        state_d   = state;
        hcnt_d    = '0;
        bcnt_d    = bcnt;
        shreg_d   = shreg;
        ch_lat_d  = ch_lat;
        prev_ch_d = prev_ch;
        res_d     = res;
        busy_d    = busy_q;
        valid_d   = 1'b0;
        cs_n_d    = cs_n_q;
        sclk_d    = sclk_q;
        saddr_d   = saddr_q;
        half_done = (hcnt == HALF_LAST);

        // One counter times every half period; it only runs inside a frame.
        if (state != IDLE && !half_done)
            hcnt_d = hcnt + 8'd1;

        case (state)
            IDLE: begin
                if (start) begin
                    state_d  = SETUP;
                    busy_d   = 1'b1;
                    cs_n_d   = 1'b0;
                    ch_lat_d = channel;
                end
            end
            SETUP: begin
                if (half_done) begin
                    state_d = SHIFT;
                    sclk_d  = 1'b0;
                    bcnt_d  = '0;
                    saddr_d = addr_bit(4'd0, ch_lat);
                end
            end
            SHIFT: begin
                if (half_done) begin
                    if (!sclk_q) begin
                        // Upper four frame bits simply fall off the top of shreg.
                        sclk_d  = 1'b1;
                        shreg_d = {shreg[SAMPLE_BITS-2:0], ADC_SDAT};
                    end else if (bcnt == BIT_LAST) begin
                        state_d = HOLD;
                        cs_n_d  = 1'b1;
                        saddr_d = 1'b0;
                    end else begin
                        bcnt_d  = bcnt + 4'd1;
                        sclk_d  = 1'b0;
                        saddr_d = addr_bit(bcnt + 4'd1, ch_lat);
                    end
                end
            end
            HOLD: begin
                if (half_done) begin
                    state_d   = IDLE;
                    valid_d   = 1'b1;
                    busy_d    = 1'b0;
                    res_d     = '{channel: prev_ch, data: shreg};
                    prev_ch_d = ch_lat;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            state   <= IDLE;
            hcnt    <= '0;
            bcnt    <= '0;
            shreg   <= '0;
            ch_lat  <= '0;
            prev_ch <= '0;
            res     <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b1;
            saddr_q <= 1'b0;
        end else begin
            state   <= state_d;
            hcnt    <= hcnt_d;
            bcnt    <= bcnt_d;
            shreg   <= shreg_d;
            ch_lat  <= ch_lat_d;
            prev_ch <= prev_ch_d;
            res     <= res_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
            saddr_q <= saddr_d;
        end
    end

    assign busy           = busy_q;
    assign sample         = res.data;
    assign sample_channel = res.channel;
    assign sample_valid   = valid_q;
    assign ADC_CS_N       = cs_n_q;
    assign ADC_SCLK       = sclk_q;
    assign ADC_SADDR      = saddr_q;

endmodule

// File: tb/tb_adc128_reader.sv
// Bench for adc128_reader: behavioural ADC model plus frame-level reference.
module tb_adc128_reader;

    localparam int CD  = 13;
    localparam int CD2 = 2;

    logic        sysclk   = 1'b0;
    logic        sysreset = 1'b1;
    logic        start    = 1'b0;
    logic [2:0]  channel  = '0;
    logic        busy, sample_valid, adc_cs_n, adc_sclk, adc_saddr;
    logic [11:0] sample;
    logic [2:0]  sample_channel;
    logic        adc_sdat = 1'b0;

    logic        start2   = 1'b0;
    logic [2:0]  channel2 = '0;
    logic        busy2, sample_valid2, adc_cs_n2, adc_sclk2, adc_saddr2;
    logic [11:0] sample2;
    logic [2:0]  sample_channel2;
    logic        adc_sdat2 = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    logic [2:0] ref_prev = '0;

    always #5 sysclk = ~sysclk;

    adc128_reader #(.CLK_DIV(CD)) dut (
        .sysclk(sysclk), .sysreset(sysreset), .start(start), .channel(channel),
        .busy(busy), .sample(sample), .sample_channel(sample_channel),
        .sample_valid(sample_valid), .ADC_CS_N(adc_cs_n), .ADC_SCLK(adc_sclk),
        .ADC_SADDR(adc_saddr), .ADC_SDAT(adc_sdat)
    );

    adc128_reader #(.CLK_DIV(CD2)) dut2 (
        .sysclk(sysclk), .sysreset(sysreset), .start(start2), .channel(channel2),
        .busy(busy2), .sample(sample2), .sample_channel(sample_channel2),
        .sample_valid(sample_valid2), .ADC_CS_N(adc_cs_n2), .ADC_SCLK(adc_sclk2),
        .ADC_SADDR(adc_saddr2), .ADC_SDAT(adc_sdat2)
    );

    // ADC model for dut: drives DOUT on SCLK falls, records DIN on rises, times SCLK runs.
    logic [11:0] model_val = '0;
    logic        prev_sclk = 1'b1, prev_csn = 1'b1;
    logic [2:0]  addr_bits = '0;
    int fall_cnt = 0, rise_cnt = 0, run_len = 0, runs = 0, bad_runs = 0;
    int csn_high_len = 0, last_gap = 0, addr_stray = 0;

    always @(negedge sysclk) begin
        if (prev_csn && !adc_cs_n) begin
            fall_cnt     <= 0;
            rise_cnt     <= 0;
            runs         <= 0;
            bad_runs     <= 0;
            run_len      <= 1;
            addr_stray   <= 0;
            addr_bits    <= '0;
            last_gap     <= csn_high_len;
            csn_high_len <= 0;
            adc_sdat     <= 1'b0;
        end else if (!prev_csn && !adc_cs_n) begin
            if (adc_sclk == prev_sclk) begin
                run_len <= run_len + 1;
            end else begin
                runs    <= runs + 1;
                run_len <= 1;
                if (run_len != CD) bad_runs <= bad_runs + 1;
                if (!adc_sclk) begin
                    if (fall_cnt < 4 || fall_cnt > 15) adc_sdat <= 1'b0;
                    else adc_sdat <= model_val[15-fall_cnt];
                    fall_cnt <= fall_cnt + 1;
                end else begin
                    if (rise_cnt >= 2 && rise_cnt <= 4) addr_bits[4-rise_cnt] <= adc_saddr;
                    else if (adc_saddr) addr_stray <= addr_stray + 1;
                    rise_cnt <= rise_cnt + 1;
                end
            end
        end else if (!prev_csn && adc_cs_n) begin
            runs <= runs + 1;
            if (run_len != CD) bad_runs <= bad_runs + 1;
            csn_high_len <= 1;
        end else if (adc_cs_n) begin
            csn_high_len <= csn_high_len + 1;
        end
        prev_csn  <= adc_cs_n;
        prev_sclk <= adc_sclk;
    end

    // Launches one frame from the current negedge and waits for its sample_valid.
    task automatic run_frame(input logic [2:0] ch, input logic [11:0] val, input int poke,
                             output int len, output int busy_low);
        model_val = val;
        channel   = ch;
        start     = 1'b1;
        len       = 0;
        busy_low  = 0;
        for (int n = 1; n <= 600; n++) begin
            @(negedge sysclk);
            start = (poke > 0 && n % poke == 0 && n < 420);
            if (start) channel = 3'($urandom_range(0, 7));
            if (sample_valid) begin
                len = n;
                break;
            end
            if (!busy) busy_low++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge sysclk);
        n_cmp++; if (adc_cs_n !== 1'b1) begin n_bad++; $display("FAIL reset_cs_n: got %b expected 1", adc_cs_n); end
        n_cmp++; if (adc_sclk !== 1'b1) begin n_bad++; $display("FAIL reset_sclk: got %b expected 1", adc_sclk); end
        n_cmp++; if ({busy, sample_valid, adc_saddr} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b expected 000", {busy, sample_valid, adc_saddr}); end
        n_cmp++; if ({sample_channel, sample} !== 15'h0) begin n_bad++; $display("FAIL reset_sample: got %h expected 0", {sample_channel, sample}); end
        n_cmp++; if (adc_cs_n2 !== 1'b1) begin n_bad++; $display("FAIL reset_cs_n2: got %b expected 1", adc_cs_n2); end
        sysreset = 1'b0;
        @(negedge sysclk);
    endtask

    task automatic test_first_frame();
        int len, bl;
        run_frame(3'd5, 12'hABC, 0, len, bl);
        n_cmp++; if (len != 443) begin n_bad++; $display("FAIL first_len: got %0d expected 443", len); end
        n_cmp++; if (bl != 0) begin n_bad++; $display("FAIL first_busy: got %0d low cycles expected 0", bl); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL first_busy_end: got %b expected 0", busy); end
        n_cmp++; if (sample !== 12'hABC) begin n_bad++; $display("FAIL first_sample: got %h expected abc", sample); end
        n_cmp++; if (sample_channel !== 3'd0) begin n_bad++; $display("FAIL first_chan: got %0d expected 0", sample_channel); end
        n_cmp++; if (addr_bits !== 3'd5) begin n_bad++; $display("FAIL first_addr: got %0d expected 5", addr_bits); end
        n_cmp++; if (addr_stray != 0) begin n_bad++; $display("FAIL first_addr_stray: got %0d expected 0", addr_stray); end
        n_cmp++; if (fall_cnt != 16) begin n_bad++; $display("FAIL first_falls: got %0d expected 16", fall_cnt); end
        n_cmp++; if (runs != 33 || bad_runs != 0) begin n_bad++; $display("FAIL first_sclk_timing: got %0d runs %0d bad expected 33 runs 0 bad", runs, bad_runs); end
        ref_prev = 3'd5;
    endtask

    task automatic test_back_to_back();
        int len, bl;
        run_frame(3'd2, 12'h123, 0, len, bl);
        n_cmp++; if (len != 443) begin n_bad++; $display("FAIL b2b_len: got %0d expected 443", len); end
        n_cmp++; if (sample !== 12'h123) begin n_bad++; $display("FAIL b2b_sample: got %h expected 123", sample); end
        n_cmp++; if (sample_channel !== ref_prev) begin n_bad++; $display("FAIL b2b_chan: got %0d expected %0d", sample_channel, ref_prev); end
        n_cmp++; if (last_gap != CD + 1) begin n_bad++; $display("FAIL b2b_cs_gap: got %0d expected %0d", last_gap, CD + 1); end
        n_cmp++; if (addr_bits !== 3'd2) begin n_bad++; $display("FAIL b2b_addr: got %0d expected 2", addr_bits); end
        ref_prev = 3'd2;
    endtask

    task automatic test_ignored_starts();
        int len, bl, extra;
        logic [11:0] v;
        v = 12'($urandom_range(0, 4095));
        run_frame(3'd3, v, 50, len, bl);
        n_cmp++; if (len != 443) begin n_bad++; $display("FAIL ign_len: got %0d expected 443", len); end
        n_cmp++; if (bl != 0) begin n_bad++; $display("FAIL ign_busy: got %0d low cycles expected 0", bl); end
        n_cmp++; if (sample !== v) begin n_bad++; $display("FAIL ign_sample: got %h expected %h", sample, v); end
        n_cmp++; if (sample_channel !== ref_prev) begin n_bad++; $display("FAIL ign_chan: got %0d expected %0d", sample_channel, ref_prev); end
        extra = 0;
        repeat (600) begin
            @(negedge sysclk);
            if (sample_valid) extra++;
        end
        n_cmp++; if (extra != 0 || busy !== 1'b0) begin n_bad++; $display("FAIL ign_extra: got %0d pulses busy %b expected 0 pulses busy 0", extra, busy); end
        ref_prev = 3'd3;
    endtask

    task automatic test_random_frames();
        int len, bl;
        logic [2:0]  c;
        logic [11:0] v;
        for (int i = 0; i < 4; i++) begin
            c = 3'($urandom_range(0, 7));
            v = 12'($urandom_range(0, 4095));
            run_frame(c, v, 0, len, bl);
            n_cmp++; if (len != 443) begin n_bad++; $display("FAIL rnd_len[%0d]: got %0d expected 443", i, len); end
            n_cmp++; if (sample !== v) begin n_bad++; $display("FAIL rnd_sample[%0d]: got %h expected %h", i, sample, v); end
            n_cmp++; if (sample_channel !== ref_prev) begin n_bad++; $display("FAIL rnd_chan[%0d]: got %0d expected %0d", i, sample_channel, ref_prev); end
            n_cmp++; if (addr_bits !== c) begin n_bad++; $display("FAIL rnd_addr[%0d]: got %0d expected %0d", i, addr_bits, c); end
            ref_prev = c;
        end
    endtask

    task automatic test_reset_mid_shift();
        int len, bl, waited, pulses;
        logic [11:0] v;
        model_val = 12'h5A5;
        channel   = 3'd6;
        start     = 1'b1;
        waited    = 0;
        @(negedge sysclk);
        start = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (fall_cnt == 8) break;
            @(negedge sysclk);
            waited++;
        end
        n_cmp++; if (fall_cnt != 8) begin n_bad++; $display("FAIL rst_reach_bit7: got %0d falls expected 8", fall_cnt); end
        sysreset = 1'b1;
        @(negedge sysclk);
        sysreset = 1'b0;
        n_cmp++; if ({adc_cs_n, adc_sclk, busy} !== 3'b110) begin n_bad++; $display("FAIL rst_outputs: got cs/sclk/busy %b expected 110", {adc_cs_n, adc_sclk, busy}); end
        n_cmp++; if ({sample_channel, sample, adc_saddr} !== 16'h0) begin n_bad++; $display("FAIL rst_sample: got %h expected 0", {sample_channel, sample, adc_saddr}); end
        pulses = 0;
        repeat (600) begin
            @(negedge sysclk);
            if (sample_valid) pulses++;
        end
        n_cmp++; if (pulses != 0) begin n_bad++; $display("FAIL rst_no_valid: got %0d pulses expected 0", pulses); end
        ref_prev = 3'd0;
        v = 12'($urandom_range(0, 4095));
        run_frame(3'd1, v, 0, len, bl);
        n_cmp++; if (sample_channel !== ref_prev) begin n_bad++; $display("FAIL rst_next_chan: got %0d expected 0", sample_channel); end
        n_cmp++; if (sample !== v || len != 443) begin n_bad++; $display("FAIL rst_next_frame: got %h len %0d expected %h len 443", sample, len, v); end
        ref_prev = 3'd1;
        if (waited < 0) $display("waited %0d", waited);
    endtask

    task automatic test_clkdiv2();
        logic [11:0] vals [2];
        logic [2:0]  chs [2];
        logic [2:0]  rp;
        logic        p_cs, p_sc, cs, sc;
        int rl, nruns, nbad, nfall, len;
        vals[0] = 12'hFFF; vals[1] = 12'h000;
        chs[0]  = 3'd3;    chs[1]  = 3'd4;
        rp = 3'd0; p_cs = 1'b1; p_sc = 1'b1;
        rl = 0; nruns = 0; nbad = 0; nfall = 0;
        for (int f = 0; f < 2; f++) begin
            start2   = 1'b1;
            channel2 = chs[f];
            len      = 0;
            for (int n = 1; n <= 200; n++) begin
                @(negedge sysclk);
                start2 = 1'b0;
                cs = adc_cs_n2;
                sc = adc_sclk2;
                if (p_cs && !cs) begin
                    nruns = 0; nbad = 0; nfall = 0; rl = 1;
                end else if (!p_cs && !cs) begin
                    if (sc == p_sc) rl++;
                    else begin
                        nruns++;
                        if (rl != CD2) nbad++;
                        rl = 1;
                        if (!sc) begin
                            adc_sdat2 = (nfall >= 4 && nfall < 16) ? vals[f][15-nfall] : 1'b0;
                            nfall++;
                        end
                    end
                end else if (!p_cs && cs) begin
                    nruns++;
                    if (rl != CD2) nbad++;
                end
                p_cs = cs;
                p_sc = sc;
                if (sample_valid2) begin
                    len = n;
                    break;
                end
            end
            n_cmp++; if (len != 69) begin n_bad++; $display("FAIL div2_len[%0d]: got %0d expected 69", f, len); end
            n_cmp++; if (sample2 !== vals[f]) begin n_bad++; $display("FAIL div2_sample[%0d]: got %h expected %h", f, sample2, vals[f]); end
            n_cmp++; if (sample_channel2 !== rp) begin n_bad++; $display("FAIL div2_chan[%0d]: got %0d expected %0d", f, sample_channel2, rp); end
            n_cmp++; if (nruns != 33 || nbad != 0 || nfall != 16) begin n_bad++; $display("FAIL div2_sclk[%0d]: got runs %0d bad %0d falls %0d expected 33/0/16", f, nruns, nbad, nfall); end
            n_cmp++; if ({busy2, adc_saddr2} !== 2'b00) begin n_bad++; $display("FAIL div2_idle[%0d]: got busy/saddr %b expected 00", f, {busy2, adc_saddr2}); end
            rp = chs[f];
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_back_to_back();
        test_ignored_starts();
        test_random_frames();
        test_reset_mid_shift();
        test_clkdiv2();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation still running at 5 ms, expected completion");
        $fatal(1);
    end

endmodule
